// File: rtl/pgm_sequencer.sv
// EPROM programmer sequencer: loads a host frame into a byte buffer, then
// programs each byte with a timed prog_ce pulse under the 25 V supply.
// Per byte: ADDR, FETCH, PULSE_CYC pulse cycles, GAP (PULSE_CYC+3 cycles).
module pgm_sequencer #(
  parameter int PULSE_CYC   = 2500000,
  parameter int SETTLE_CYC  = 50000,
  parameter int TIMEOUT_CYC = 5000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        new_rx_data,
  input  logic        tx_busy,
  output logic [7:0]  tx_data,
  output logic        new_tx_data,
  output logic        buf_we,
  output logic [10:0] buf_addr,
  output logic [7:0]  buf_wdata,
  input  logic [7:0]  buf_rdata,
  output logic [10:0] ep_addr,
  output logic [7:0]  ep_data,
  output logic        ale,
  output logic        prog_ce,
  output logic        vdd_25,
  output logic        busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_LOAD, S_VUP, S_ADDR,
    S_FETCH, S_PULSE, S_GAP, S_VDOWN, S_RESP
  } state_t;

  localparam logic [7:0]  CMD_PGM    = 8'h50;
  localparam logic [7:0]  CMD_STAT   = 8'h53;
  localparam logic [7:0]  RSP_OK     = 8'h4B;
  localparam logic [7:0]  RSP_TMO    = 8'h45;
  localparam logic [7:0]  RSP_BAD    = 8'h3F;
  localparam logic [31:0] PULSE_LAST  = 32'(PULSE_CYC - 1);
  localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYC - 1);
  localparam logic [31:0] TMO_LAST    = 32'(TIMEOUT_CYC - 1);

  state_t      state_q, state_d;
  logic [2:0]  hi3_q, hi3_d;
  logic [11:0] len_q, len_d;
  logic [11:0] byte_cnt_q, byte_cnt_d;
  logic [10:0] idx_q, idx_d;
  logic [31:0] tmo_q, tmo_d;
  logic [31:0] tim_q, tim_d;
  logic [7:0]  code_q, code_d;
  logic        last_ok_q, last_ok_d;
  logic [10:0] ep_addr_q, ep_addr_d;
  logic [7:0]  ep_data_q, ep_data_d;
  logic        prog_ce_q, prog_ce_d;
  logic        vdd_q, vdd_d;

  logic        last_idx;
  logic        tmo_hit;

  // Program index has reached the final byte of the frame.
  assign last_idx = ({1'b0, idx_q} == (len_q - 12'd1));
  // A full TIMEOUT_CYC run of cycles without a host byte.
  assign tmo_hit  = !new_rx_data && (tmo_q == TMO_LAST);

  // State and datapath registers; reset clears everything asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      hi3_q      <= '0;
      len_q      <= '0;
      byte_cnt_q <= '0;
      idx_q      <= '0;
      tmo_q      <= '0;
      tim_q      <= '0;
      code_q     <= '0;
      last_ok_q  <= 1'b0;
      ep_addr_q  <= '0;
      ep_data_q  <= '0;
      prog_ce_q  <= 1'b0;
      vdd_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hi3_q      <= hi3_d;
      len_q      <= len_d;
      byte_cnt_q <= byte_cnt_d;
      idx_q      <= idx_d;
      tmo_q      <= tmo_d;
      tim_q      <= tim_d;
      code_q     <= code_d;
      last_ok_q  <= last_ok_d;
      ep_addr_q  <= ep_addr_d;
      ep_data_q  <= ep_data_d;
      prog_ce_q  <= prog_ce_d;
      vdd_q      <= vdd_d;
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_d    = state_q;
    hi3_d      = hi3_q;
    len_d      = len_q;
    byte_cnt_d = byte_cnt_q;
    idx_d      = idx_q;
    tmo_d      = tmo_q;
    tim_d      = tim_q;
    code_d     = code_q;
    last_ok_d  = last_ok_q;
    ep_addr_d  = ep_addr_q;
    ep_data_d  = ep_data_q;
    case (state_q)
      S_IDLE: begin
        if (new_rx_data) begin
          if (rx_data == CMD_PGM) begin
            tmo_d   = '0;
            state_d = S_LEN_HI;
          end else if (rx_data == CMD_STAT) begin
            code_d  = {7'b0, last_ok_q};
            state_d = S_RESP;
          end else begin
            code_d    = RSP_BAD;
            last_ok_d = 1'b0;
            state_d   = S_RESP;
          end
        end
      end
      S_LEN_HI, S_LEN_LO, S_LOAD: begin
        if (tmo_hit) begin
          code_d    = RSP_TMO;
          last_ok_d = 1'b0;
          state_d   = S_RESP;
        end else if (!new_rx_data) begin
          tmo_d = tmo_q + 32'd1;
        end else begin
          tmo_d = '0;
          if (state_q == S_LEN_HI) begin
            hi3_d   = rx_data[2:0];
            state_d = S_LEN_LO;
          end else if (state_q == S_LEN_LO) begin
            len_d      = 12'({hi3_q, rx_data}) + 12'd1;
            byte_cnt_d = '0;
            idx_d      = '0;
            state_d    = S_LOAD;
          end else begin
            byte_cnt_d = byte_cnt_q + 12'd1;
            if ((byte_cnt_q + 12'd1) == len_q) begin
              // Index returns to 0 here so it never wraps on a 2048-byte frame.
              idx_d   = '0;
              tim_d   = '0;
              state_d = S_VUP;
            end else begin
              idx_d = idx_q + 11'd1;
            end
          end
        end
      end
      S_VUP: begin
        if (tim_q == SETTLE_LAST) begin
          tim_d     = '0;
          ep_addr_d = idx_q;
          state_d   = S_ADDR;
        end else begin
          tim_d = tim_q + 32'd1;
        end
      end
      S_ADDR: begin
        // buf_addr already held this index last cycle, so read data is valid now.
        ep_data_d = buf_rdata;
        state_d   = S_FETCH;
      end
      S_FETCH: begin
        ep_data_d = buf_rdata;
        tim_d     = '0;
        state_d   = S_PULSE;
      end
      S_PULSE: begin
        if (tim_q == PULSE_LAST) begin
          tim_d   = '0;
          state_d = S_GAP;
        end else begin
          tim_d = tim_q + 32'd1;
        end
      end
      S_GAP: begin
        if (last_idx) begin
          tim_d   = '0;
          state_d = S_VDOWN;
        end else begin
          idx_d     = idx_q + 11'd1;
          ep_addr_d = idx_q + 11'd1;
          state_d   = S_ADDR;
        end
      end
      S_VDOWN: begin
        if (tim_q == SETTLE_LAST) begin
          code_d    = RSP_OK;
          last_ok_d = 1'b1;
          state_d   = S_RESP;
        end else begin
          tim_d = tim_q + 32'd1;
        end
      end
      S_RESP: begin
        if (!tx_busy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // High-voltage controls are registered from the upcoming state.
    prog_ce_d = (state_d == S_PULSE);
    vdd_d     = (state_d inside {S_VUP, S_ADDR, S_FETCH, S_PULSE, S_GAP});
  end

  // Output decode; during GAP the buffer address runs one index ahead.
  always_comb begin
    buf_we      = (state_q == S_LOAD) && new_rx_data;
    buf_wdata   = rx_data;
    buf_addr    = ((state_q == S_GAP) && !last_idx) ? (idx_q + 11'd1) : idx_q;
    ale         = (state_q == S_ADDR);
    new_tx_data = (state_q == S_RESP) && !tx_busy;
    tx_data     = code_q;
    busy        = (state_q != S_IDLE);
    ep_addr     = ep_addr_q;
    ep_data     = ep_data_q;
    prog_ce     = prog_ce_q;
    vdd_25      = vdd_q;
  end

endmodule

// File: doc/pgm_sequencer.md
PGM_SEQUENCER -- requirements
Module: pgm_sequencer

Interface
REQ-001 The block SHALL have parameters: PULSE_CYC, default 2500000, PROG_CE high time per byte in clk cycles (50 ms at 50 MHz).
REQ-002 SETTLE_CYC, default 50000, VDD settle time in clk cycles.
REQ-003 TIMEOUT_CYC, default 5000000, maximum gap between host bytes during load.
REQ-004 Ports SHALL be:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
rx_data  in  8  byte from UART receiver
new_rx_data  in  1  one-cycle strobe, rx_data valid
tx_busy  in  1  UART transmitter busy
tx_data  out  8  response byte to UART
new_tx_data  out  1  one-cycle transmit strobe
buf_we  out  1  buffer write enable
buf_addr  out  11  buffer address
buf_wdata  out  8  buffer write data
buf_rdata  in  8  buffer read data, valid 1 cycle after buf_addr
ep_addr  out  11  EPROM address bus
ep_data  out  8  EPROM data bus
ale  out  1  EPROM address latch strobe
prog_ce  out  1  EPROM program pulse
vdd_25  out  1  high selects 25 V programming supply
busy  out  1  high in any state other than IDLE

Function
REQ-005 Host commands SHALL be: 0x50 program, 0x53 status; any other byte in IDLE SHALL produce response 0x3F.
REQ-006 Program frame SHALL be 0x50, LEN_HI, LEN_LO, then N data bytes, N = {LEN_HI[2:0],LEN_LO}+1 (1..2048); LEN_HI[7:3] ignored.
REQ-007 States SHALL be IDLE, LEN_HI, LEN_LO, LOAD, VUP, ADDR, FETCH, PULSE, GAP, VDOWN, RESP.
REQ-008 LOAD: each new_rx_data SHALL assert buf_we for exactly that cycle with buf_wdata=rx_data, buf_addr=load index (starting 0, +1 per byte); after byte N go to VUP.
REQ-009 A byte counter SHALL be 12 bits; load index and program index SHALL be 11 bits and never wrap within a frame.
REQ-010 Timeout counter SHALL reset on every new_rx_data in LEN_HI/LEN_LO/LOAD; reaching TIMEOUT_CYC SHALL abort to RESP with code 0x45, vdd_25 never raised.
REQ-011 VUP: vdd_25=1, hold SETTLE_CYC cycles, then ADDR with program index 0.
REQ-012 ADDR: ep_addr=program index, ale=1 for exactly 1 cycle; FETCH: buf_addr=program index, wait 1 cycle, latch buf_rdata to ep_data.
REQ-013 PULSE: prog_ce=1 for exactly PULSE_CYC cycles; ep_addr and ep_data SHALL be stable throughout and 1 cycle either side.
REQ-014 GAP: prog_ce=0 for 1 cycle; if program index = N-1 go VDOWN, else index+1 and ADDR.
REQ-015 VDOWN: vdd_25=0, hold SETTLE_CYC cycles, then RESP with code 0x4B.
REQ-016 RESP: wait until tx_busy=0, assert new_tx_data 1 cycle with tx_data=code, return IDLE next cycle.
REQ-017 Status command SHALL respond {7'b0, last_ok} where last_ok=1 after a completed program, 0 after reset, timeout or 0x3F.
REQ-018 new_rx_data in VUP..VDOWN or RESP SHALL be ignored (no buffer write, no state change).
REQ-019 prog_ce and vdd_25 SHALL be registered outputs; prog_ce=1 only while vdd_25=1.
REQ-020 Total program time per byte SHALL be PULSE_CYC+3 cycles (ADDR 1, FETCH 1, PULSE, GAP 1).

Reset
REQ-021 rst SHALL immediately force IDLE, vdd_25=0, prog_ce=0, ale=0, buf_we=0, new_tx_data=0, tx_data=0, ep_addr=0, ep_data=0, buf_addr=0, last_ok=0, all counters 0, independent of clk.
REQ-022 rst asserted mid-PULSE SHALL drop prog_ce and vdd_25 in the same instant; no response byte after release.

Verification
REQ-023 PULSE_CYC=8, SETTLE_CYC=4: send 50 00 02 A1 B2 C3 -> buffer 0..2=A1,B2,C3; three 8-cycle prog_ce pulses at ep_addr 0,1,2 with ep_data A1,B2,C3; response 0x4B; status then returns 0x01.
REQ-024 Send 50 07 FF + 2048 bytes (value=addr[7:0]) -> 2048 pulses, last ep_addr=0x7FF, ep_data=0xFF, no wrap, response 0x4B.
REQ-025 TIMEOUT_CYC=20: send 50 00 05 11 then silence -> 0x45 after 20 idle cycles, vdd_25 never high, status returns 0x00.
REQ-026 Send 0x7A in IDLE -> single 0x3F; tx_busy held high 10 cycles before it -> new_tx_data delayed until tx_busy low.
REQ-027 Assert rst during 3rd cycle of a pulse -> prog_ce, vdd_25, busy 0 asynchronously; next 50 00 00 5A frame programs normally.
REQ-028 Extra rx bytes injected during PULSE -> buffer contents and pulse sequence unchanged.
